// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared defaults and feedback parity helper for the LFSR generator
//
// Purpose : default register geometry (WIDTH, TAPS, SEED) and the feedback
//           parity function used by lfsr_gen.
// Contents: DEF_WIDTH, DEF_TAPS, DEF_SEED localparams; fb_parity().

package lfsr_pkg;

  localparam int          DEF_WIDTH = 7;
  localparam logic [31:0] DEF_TAPS  = 32'h0000_0060;
  localparam logic [31:0] DEF_SEED  = 32'h0000_007F;

  // Feedback bit: XOR of every state bit whose mask bit is set.
  // Operands are carried at 32 bits so one function serves every legal WIDTH;
  // callers zero-extend, and zero bits contribute nothing to the parity.
  function automatic logic fb_parity(input logic [31:0] state, input logic [31:0] mask);
    return ^(state & mask);
  endfunction

endpackage

// File: rtl/lfsr_period_mon.sv
// rtl/lfsr_period_mon.sv - measures LFSR sequence period against a reference state
//
// Purpose : counts steps since the reference state was (re)established and
//           reports the count when the register returns to that state.
// Ports   :
//   clk            in   clock, rising edge
//   rst            in   synchronous active-high reset
//   i_step         in   register advances this cycle
//   i_next_state   in   value the register takes after this step
//   i_ref          in   reference state the period is measured against
//   i_set_ref      in   reference is being (re)loaded this cycle; restart count
//   o_period       out  last measured period (WIDTH+1 bits)
//   o_period_valid out  one-cycle pulse when o_period updates

module lfsr_period_mon #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_next_state,
  input  logic [WIDTH-1:0] i_ref,
  input  logic             i_set_ref,
  output logic [WIDTH:0]   o_period,
  output logic             o_period_valid
);

  localparam int          CW      = WIDTH + 1;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_period;
  logic          r_period_valid;
  logic          w_match;
  logic          w_sat;

  assign w_match = (i_next_state == i_ref);
  assign w_sat   = (r_cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt          <= '0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
    end else begin
      r_period_valid <= 1'b0;
      if (i_set_ref) begin
        r_cnt <= '0;
      end else if (i_step) begin
        if (w_match && !w_sat) begin
          // cnt is at most CNT_MAX-1 here, so cnt+1 cannot wrap.
          r_period       <= r_cnt + CNT_ONE;
          r_period_valid <= 1'b1;
          r_cnt          <= '0;
        end else if (!w_sat) begin
          r_cnt <= r_cnt + CNT_ONE;
        end
        // A saturated count is no longer a trustworthy period, so it is
        // held and never reported.
      end
    end
  end

  assign o_period       = r_period;
  assign o_period_valid = r_period_valid;

endmodule

// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - Fibonacci-style LFSR with load, lockup recovery and period measurement
//
// Purpose : shift register advancing toward the MSB with XOR feedback into
//           bit 0; supports parallel load, recovers from the all-zero state
//           by reloading SEED, and measures the sequence period.
// Ports   :
//   clk            in   clock, rising edge
//   rst            in   synchronous active-high reset
//   en             in   advance one step
//   load           in   replace state with seed_in (overrides en)
//   seed_in        in   value loaded when load=1
//   state_o        out  current register contents
//   bit_o          out  serial output, state_o MSB
//   lockup_o       out  state_o is all-zero
//   period_o       out  last measured period (WIDTH+1 bits)
//   period_valid_o out  one-cycle pulse when period_o updates

module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_TAPS),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] state_o,
  output logic             bit_o,
  output logic             lockup_o,
  output logic [WIDTH:0]   period_o,
  output logic             period_valid_o
);

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] r_ref;
  logic             w_fb;
  logic [WIDTH-1:0] w_next;
  logic             w_lockup;
  logic             w_step;
  logic             w_recover;
  logic             w_set_ref;

  assign w_fb      = fb_parity(32'(r_state), 32'(TAPS));
  assign w_next    = {r_state[WIDTH-2:0], w_fb};
  assign w_lockup  = (r_state == '0);

  // An enable while locked up reseeds instead of stepping; load wins over en.
  assign w_step    = en & ~load & ~w_lockup;
  assign w_recover = en & ~load &  w_lockup;
  assign w_set_ref = load | w_recover;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SEED;
      r_ref   <= SEED;
    end else if (load) begin
      r_state <= seed_in;
      r_ref   <= seed_in;
    end else if (w_recover) begin
      r_state <= SEED;
      r_ref   <= SEED;
    end else if (w_step) begin
      r_state <= w_next;
    end
  end

  lfsr_period_mon #(
    .WIDTH (WIDTH)
  ) u_period_mon (
    .clk            (clk),
    .rst            (rst),
    .i_step         (w_step),
    .i_next_state   (w_next),
    .i_ref          (r_ref),
    .i_set_ref      (w_set_ref),
    .o_period       (period_o),
    .o_period_valid (period_valid_o)
  );

  assign state_o  = r_state;
  assign bit_o    = r_state[WIDTH-1];
  assign lockup_o = w_lockup;

endmodule

// File: tb/tb_lfsr_gen.sv
// tb/tb_lfsr_gen.sv - directed self-checking bench for lfsr_gen

module tb_lfsr_gen;

  logic       clk;
  logic       rst;
  logic       en;
  logic       load;
  logic [6:0] seed_in;

  logic [6:0] state_o;
  logic       bit_o;
  logic       lockup_o;
  logic [7:0] period_o;
  logic       period_valid_o;

  logic [6:0] rot_state_o;
  logic       rot_bit_o;
  logic       rot_lockup_o;
  logic [7:0] rot_period_o;
  logic       rot_period_valid_o;

  int errors;
  int checks;

  lfsr_gen u_dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .load           (load),
    .seed_in        (seed_in),
    .state_o        (state_o),
    .bit_o          (bit_o),
    .lockup_o       (lockup_o),
    .period_o       (period_o),
    .period_valid_o (period_valid_o)
  );

  lfsr_gen #(
    .WIDTH (7),
    .TAPS  (7'h40),
    .SEED  (7'h01)
  ) u_rot (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .load           (load),
    .seed_in        (seed_in),
    .state_o        (rot_state_o),
    .bit_o          (rot_bit_o),
    .lockup_o       (rot_lockup_o),
    .period_o       (rot_period_o),
    .period_valid_o (rot_period_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; load = 1'b0; seed_in = 7'h00;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; load = 1'b1; seed_in = 7'h2A;
    tick();
    rst = 1'b0; en = 1'b0; load = 1'b0;
    checks++; if (state_o !== 7'h7F) begin errors++; $display("FAIL reset_state: got %h expected 7f", state_o); end
    checks++; if (period_o !== 8'd0) begin errors++; $display("FAIL reset_period: got %0d expected 0", period_o); end
    checks++; if (period_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", period_valid_o); end
    checks++; if (lockup_o !== 1'b0) begin errors++; $display("FAIL reset_lockup: got %b expected 0", lockup_o); end
    checks++; if (bit_o !== 1'b1) begin errors++; $display("FAIL reset_bit: got %b expected 1", bit_o); end
  endtask

  task automatic test_sequence();
    logic [6:0] exp_seq [8];
    exp_seq = '{7'h7E, 7'h7C, 7'h78, 7'h70, 7'h60, 7'h40, 7'h01, 7'h02};
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (state_o !== exp_seq[i]) begin errors++; $display("FAIL seq_state[%0d]: got %h expected %h", i, state_o, exp_seq[i]); end
      checks++; if (bit_o !== exp_seq[i][6]) begin errors++; $display("FAIL seq_bit[%0d]: got %b expected %b", i, bit_o, exp_seq[i][6]); end
    end
    en = 1'b0;
  endtask

  task automatic test_full_period();
    logic exp_v;
    do_reset();
    en = 1'b1;
    for (int i = 1; i <= 254; i++) begin
      tick();
      exp_v = (i == 127) || (i == 254);
      checks++; if (period_valid_o !== exp_v) begin errors++; $display("FAIL full_valid[%0d]: got %b expected %b", i, period_valid_o, exp_v); end
      if (i == 127) begin
        checks++; if (state_o !== 7'h7F) begin errors++; $display("FAIL full_state127: got %h expected 7f", state_o); end
        checks++; if (period_o !== 8'd127) begin errors++; $display("FAIL full_period127: got %0d expected 127", period_o); end
      end
    end
    checks++; if (period_o !== 8'd127) begin errors++; $display("FAIL full_period254: got %0d expected 127", period_o); end
    en = 1'b0;
  endtask

  task automatic test_hold();
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (state_o !== 7'h78) begin errors++; $display("FAIL hold_state[%0d]: got %h expected 78", i, state_o); end
      checks++; if (period_valid_o !== 1'b0) begin errors++; $display("FAIL hold_valid[%0d]: got %b expected 0", i, period_valid_o); end
    end
    en = 1'b1;
    for (int i = 0; i < 124; i++) tick();
    en = 1'b0;
    checks++; if (state_o !== 7'h7F) begin errors++; $display("FAIL hold_state_end: got %h expected 7f", state_o); end
    checks++; if (period_valid_o !== 1'b1) begin errors++; $display("FAIL hold_valid_end: got %b expected 1", period_valid_o); end
    checks++; if (period_o !== 8'd127) begin errors++; $display("FAIL hold_period: got %0d expected 127", period_o); end
    tick();
    checks++; if (period_valid_o !== 1'b0) begin errors++; $display("FAIL hold_pulse_width: got %b expected 0", period_valid_o); end
    checks++; if (period_o !== 8'd127) begin errors++; $display("FAIL hold_period_keep: got %0d expected 127", period_o); end
  endtask

  task automatic test_rotation();
    logic [6:0] exp_s;
    do_reset();
    checks++; if (rot_state_o !== 7'h01) begin errors++; $display("FAIL rot_reset: got %h expected 01", rot_state_o); end
    en = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      exp_s = 7'h01 << (i % 7);
      checks++; if (rot_state_o !== exp_s) begin errors++; $display("FAIL rot_state[%0d]: got %h expected %h", i, rot_state_o, exp_s); end
      checks++; if (rot_period_valid_o !== (i == 7)) begin errors++; $display("FAIL rot_valid[%0d]: got %b expected %b", i, rot_period_valid_o, (i == 7)); end
    end
    checks++; if (rot_period_o !== 8'd7) begin errors++; $display("FAIL rot_period: got %0d expected 7", rot_period_o); end
    en = 1'b0;
  endtask

  task automatic test_lockup();
    do_reset();
    load = 1'b1; seed_in = 7'h00;
    tick();
    load = 1'b0;
    checks++; if (state_o !== 7'h00) begin errors++; $display("FAIL lock_state: got %h expected 00", state_o); end
    checks++; if (lockup_o !== 1'b1) begin errors++; $display("FAIL lock_flag: got %b expected 1", lockup_o); end
    en = 1'b1;
    tick();
    checks++; if (state_o !== 7'h7F) begin errors++; $display("FAIL lock_recover: got %h expected 7f", state_o); end
    checks++; if (lockup_o !== 1'b0) begin errors++; $display("FAIL lock_clear: got %b expected 0", lockup_o); end
    checks++; if (period_valid_o !== 1'b0) begin errors++; $display("FAIL lock_valid: got %b expected 0", period_valid_o); end
    tick();
    checks++; if (state_o !== 7'h7E) begin errors++; $display("FAIL lock_step: got %h expected 7e", state_o); end
    checks++; if (period_valid_o !== 1'b0) begin errors++; $display("FAIL lock_valid2: got %b expected 0", period_valid_o); end
    en = 1'b0;
  endtask

  task automatic test_load_en();
    do_reset();
    load = 1'b1; en = 1'b1; seed_in = 7'h15;
    tick();
    load = 1'b0;
    checks++; if (state_o !== 7'h15) begin errors++; $display("FAIL load_state: got %h expected 15", state_o); end
    checks++; if (period_valid_o !== 1'b0) begin errors++; $display("FAIL load_valid: got %b expected 0", period_valid_o); end
    for (int i = 1; i <= 127; i++) begin
      tick();
      checks++; if (period_valid_o !== (i == 127)) begin errors++; $display("FAIL load_pulse[%0d]: got %b expected %b", i, period_valid_o, (i == 127)); end
    end
    checks++; if (state_o !== 7'h15) begin errors++; $display("FAIL load_return: got %h expected 15", state_o); end
    checks++; if (period_o !== 8'd127) begin errors++; $display("FAIL load_period: got %0d expected 127", period_o); end
    en = 1'b0;
  endtask

  task automatic test_rst_mid();
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 49; i++) tick();
    rst = 1'b1; load = 1'b1; seed_in = 7'h15;
    tick();
    rst = 1'b0; load = 1'b0;
    checks++; if (state_o !== 7'h7F) begin errors++; $display("FAIL mid_state: got %h expected 7f", state_o); end
    checks++; if (period_valid_o !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", period_valid_o); end
    checks++; if (period_o !== 8'd0) begin errors++; $display("FAIL mid_period_clr: got %0d expected 0", period_o); end
    for (int i = 1; i <= 127; i++) begin
      tick();
      checks++; if (period_valid_o !== (i == 127)) begin errors++; $display("FAIL mid_pulse[%0d]: got %b expected %b", i, period_valid_o, (i == 127)); end
    end
    checks++; if (period_o !== 8'd127) begin errors++; $display("FAIL mid_period: got %0d expected 127", period_o); end
    en = 1'b0;
  endtask

  initial begin
    errors = 0; checks = 0;
    rst = 1'b1; en = 1'b0; load = 1'b0; seed_in = 7'h00;
    test_reset();
    test_sequence();
    test_full_period();
    test_hold();
    test_rotation();
    test_lockup();
    test_load_en();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lfsr_gen.md
LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 Parameter WIDTH, default 7, register length in bits (legal 3..32).
REQ-002 Parameter TAPS, default 7'h60, feedback mask (bit i set = state[i] enters feedback XOR); width WIDTH.
REQ-003 Parameter SEED, default 7'h7F, reset/recovery state; width WIDTH; nonzero.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 en  input  1  advance LFSR one step this cycle.
REQ-007 load  input  1  replace state with seed_in this cycle.
REQ-008 seed_in  input  WIDTH  value loaded when load=1.
REQ-009 state_o  output  WIDTH  current register contents.
REQ-010 bit_o  output  1  serial output = state_o[WIDTH-1].
REQ-011 lockup_o  output  1  high while state_o is all-zero.
REQ-012 period_o  output  WIDTH+1  last measured sequence period.
REQ-013 period_valid_o  output  1  one-cycle pulse when period_o updates.

Function
REQ-014 Step: fb = XOR of state[i] for all i with TAPS[i]=1; next state = {state[WIDTH-2:0], fb} (shift toward MSB, fb into bit 0).
REQ-015 Priority each cycle: rst > load > en > hold.
REQ-016 load=1: state <= seed_in, ref <= seed_in, cnt <= 0, no period pulse; en ignored that cycle.
REQ-017 en=0 and load=0: state, ref, cnt hold; period_valid_o=0.
REQ-018 en=1 with state all-zero (lockup): state <= SEED, ref <= SEED, cnt <= 0, no step, no period pulse.
REQ-019 lockup_o is combinational from state_o==0; zero seed_in is legal and sets lockup_o next cycle.
REQ-020 Internal ref register holds last loaded/reset state; cnt (WIDTH+1 bits) counts steps since ref was set.
REQ-021 On a step whose next state equals ref: period_o <= cnt+1, period_valid_o <= 1 next cycle, cnt <= 0.
REQ-022 Otherwise on a step: cnt <= cnt+1, saturating at all-ones; saturated cnt never produces a period pulse.
REQ-023 period_valid_o is registered, high exactly one cycle per period completion; period_o holds between updates.
REQ-024 No combinational path from en/load/seed_in to any output except via registered state.

Reset
REQ-025 rst=1: state <= SEED, ref <= SEED, cnt <= 0, period_o <= 0, period_valid_o <= 0.
REQ-026 rst mid-sequence discards partial count; rst overrides load and en in the same cycle.
REQ-027 No initial blocks relied on for functional state; outputs defined only after first rst cycle.

Structure
REQ-028 Shared package lfsr_pkg holds default WIDTH, TAPS, SEED constants and a function computing feedback parity from state and mask.
REQ-029 Single module; period measurement may be a sub-module lfsr_period_mon (inputs step, next_state, ref, set_ref; outputs period_o, period_valid_o).

Verification
REQ-030 Defaults, rst then en=1: state_o sequence 7F,7E,7C,78,70,60,40,01; bit_o = MSB each cycle.
REQ-031 Defaults, en=1 continuously 127 cycles after rst: state_o returns to 7F, period_valid_o pulses once with period_o=127, repeats every 127 cycles.
REQ-032 TAPS=7'h40 override, SEED=7'h01: rotation sequence 01,02,...,40,01; period_o=7.
REQ-033 load seed_in=0, then en=1: lockup_o=1 one cycle, next state 7F, lockup_o=0, no period pulse.
REQ-034 load=1 and en=1 same cycle with seed_in=7'h15: state_o=15, cnt=0; 127 subsequent steps yield period_o=127.
REQ-035 rst asserted during step 50 with en=1 and load=1: state_o=7F next cycle, period_valid_o=0, next full period reports 127.
